// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with 2-entry prefetch FIFO
//
// Fetches from a combinational instruction memory at FetchPc and queues
// {pc, instruction} pairs in a 2-entry FIFO that feeds decode through a
// valid/ready handshake. It supports start, branch redirect and halt.
//
// Ports:
//   Clk          - clock, rising edge
//   Reset_n      - asynchronous active-low reset
//   Start        - begin execution at StartAddr (IDLE/DONE only)
//   StartAddr    - first fetch address
//   Address      - memory read address (always FetchPc)
//   Instruction  - memory read data for Address, same cycle
//   InstOut      - head-of-FIFO instruction (0 when empty)
//   InstPc       - address of InstOut (0 when empty)
//   InstValid    - FIFO non-empty
//   InstReady    - decode accepts head
//   BranchTaken  - redirect fetch to BranchTarget
//   BranchTarget - redirect address
//   Halt         - stop execution
//   Done         - program halted
module fetch_unit #(
  parameter int ADDR_W = 10,
  parameter int INST_W = 9
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  output logic [ADDR_W-1:0] Address,
  input  logic [INST_W-1:0] Instruction,
  output logic [INST_W-1:0] InstOut,
  output logic [ADDR_W-1:0] InstPc,
  output logic              InstValid,
  input  logic              InstReady,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              Halt,
  output logic              Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  // After a start or redirect, one cycle passes with no push so the first
  // instruction appears two edges after the request.
  logic              skip;
  logic [1:0]        count;
  logic [ADDR_W-1:0] pc0, pc1;
  logic [INST_W-1:0] ins0, ins1;
  logic              valid;
  logic              pop, push, starting, halting, branching;

  assign valid     = (count != 2'd0);
  assign Address   = fetch_pc;
  assign InstValid = valid;
  assign InstOut   = valid ? ins0 : '0;
  assign InstPc    = valid ? pc0 : '0;
  assign Done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    starting  = 1'b0;
    halting   = 1'b0;
    branching = 1'b0;
    push      = 1'b0;
    pop       = valid && InstReady;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_nxt = RUN;
          starting  = 1'b1;
        end
      end
      RUN: begin
        if (Halt) begin
          state_nxt = DONE;
          halting   = 1'b1;
        end else if (BranchTaken) begin
          branching = 1'b1;
        end else begin
          push = !skip && ((count != 2'd2) || pop);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_pc <= '0;
      skip     <= 1'b0;
      count    <= 2'd0;
      pc0      <= '0;
      pc1      <= '0;
      ins0     <= '0;
      ins1     <= '0;
    end else if (starting) begin
      fetch_pc <= StartAddr;
      skip     <= 1'b1;
      count    <= 2'd0;
    end else if (halting) begin
      skip     <= 1'b0;
      count    <= 2'd0;
    end else if (branching) begin
      // Any handshake this cycle completes externally; the FIFO is simply dropped.
      fetch_pc <= BranchTarget;
      skip     <= 1'b1;
      count    <= 2'd0;
    end else if (state == RUN) begin
      skip <= 1'b0;
      if (push) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            pc0  <= fetch_pc;
            ins0 <= Instruction;
          end else begin
            pc1  <= fetch_pc;
            ins1 <= Instruction;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          pc0   <= pc1;
          ins0  <= ins1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            pc0  <= fetch_pc;
            ins0 <= Instruction;
          end else begin
            pc0  <= pc1;
            ins0 <= ins1;
            pc1  <= fetch_pc;
            ins1 <= Instruction;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
